pong_vcounter: RTL

Vertical line counter for the Pong video timing chain. It advances once per scan line on the rising edge of the horizontal reset. It publishes the 9-bit line count (v1..v256) and the vertical reset. It sits between the horizontal counter (source of `hreset`) and the vertical sync/blank stage, which consumes `vreset`, `v4`, `v8` and `v16`.

---
 rtl/pong_vcounter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pong_vcounter.sv
// pong_vcounter: vertical line counter for the Pong video timing chain.
// Advances once per rising edge of hreset, wraps at V_TOTAL-1, and
// publishes the line count, its bit aliases, vreset and a line tick.
// Optional frame counter is built when VCOUNTER_FRAME_EN is defined.
module pong_vcounter #(
  parameter int unsigned V_TOTAL = 262
) (
  input  logic       mclk,
  input  logic       _reset,
  input  logic       hreset,
  output logic [8:0] v,
  output logic       v1,
  output logic       v2,
  output logic       v4,
  output logic       v8,
  output logic       v16,
  output logic       v32,
  output logic       v64,
  output logic       v128,
  output logic       v256,
  output logic       vreset,
  output logic       _vreset,
  output logic       line_tick
`ifdef VCOUNTER_FRAME_EN
  ,
  output logic [7:0] frame,
  output logic       frame_tick
`endif
);

  localparam int unsigned VW = 9;
  localparam int unsigned FW = 8;
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  // Reject frame lengths the 9-bit counter cannot represent.
  if (V_TOTAL < 2 || V_TOTAL > 512) begin : g_bad_v_total
    $error("pong_vcounter: V_TOTAL must be in 2..512");
  end

  logic          hreset_dly_q, hreset_dly_d;
  logic [VW-1:0] v_q, v_d;
  logic          vreset_q, vreset_d;
  logic          line_tick_q, line_tick_d;
  logic          adv;
  logic          at_last;
`ifdef VCOUNTER_FRAME_EN
  logic [FW-1:0] frame_q, frame_d;
  logic          frame_tick_q, frame_tick_d;
`endif

  // Next-state: edge detect on hreset, line count with wrap, vreset lookahead.
  always_comb begin
    hreset_dly_d = hreset;
    v_d          = v_q;
    line_tick_d  = 1'b0;
    adv          = hreset & ~hreset_dly_q;
    at_last      = (v_q == V_LAST);
    if (adv) begin
      v_d         = at_last ? '0 : v_q + VW'(1);
      line_tick_d = 1'b1;
    end
    // vreset tracks the count that will be held after this edge.
    vreset_d = (v_d == V_LAST);
  end

`ifdef VCOUNTER_FRAME_EN
  // Frame counter: bumps on every wrap of the line count.
  always_comb begin
    frame_d      = frame_q;
    frame_tick_d = 1'b0;
    if (adv && at_last) begin
      frame_d      = frame_q + FW'(1);
      frame_tick_d = 1'b1;
    end
  end

  // Frame state registers.
  always_ff @(posedge mclk or negedge _reset) begin
    if (!_reset) begin
      frame_q      <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_q      <= frame_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign frame      = frame_q;
  assign frame_tick = frame_tick_q;
`else
  // Frame counter not built; line timing is unaffected.
`endif

  // Line state registers; hreset_dly resets high so a held hreset is not an edge.
  always_ff @(posedge mclk or negedge _reset) begin
    if (!_reset) begin
      hreset_dly_q <= 1'b1;
      v_q          <= '0;
      vreset_q     <= 1'b0;
      line_tick_q  <= 1'b0;
    end else begin
      hreset_dly_q <= hreset_dly_d;
      v_q          <= v_d;
      vreset_q     <= vreset_d;
      line_tick_q  <= line_tick_d;
    end
  end

  assign v         = v_q;
  assign v1        = v_q[0];
  assign v2        = v_q[1];
  assign v4        = v_q[2];
  assign v8        = v_q[3];
  assign v16       = v_q[4];
  assign v32       = v_q[5];
  assign v64       = v_q[6];
  assign v128      = v_q[7];
  assign v256      = v_q[8];
  assign vreset    = vreset_q;
  assign _vreset   = ~vreset_q;
  assign line_tick = line_tick_q;

endmodule
